// File: rtl/spaceinvaders_pkg.sv
// Shared Space Invaders definitions: default playfield sizing reused by the
// formation, bullet and fire-scheduler blocks, plus the fire scheduler states.
package spaceinvaders_pkg;

    localparam int DEF_NUM_COLS        = 11;
    localparam int DEF_NUM_SLOTS       = 3;
    localparam int DEF_COOLDOWN_FRAMES = 16;

    // One-hot so each state maps to a single flop bit.
    typedef enum logic [2:0] {
        FS_IDLE     = 3'b001,
        FS_COOLDOWN = 3'b010,
        FS_OFFER    = 3'b100
    } fire_sched_states_t;

endpackage

// File: rtl/enemy_fire_sched_rr_pick.sv
// Rotating-priority encoder: returns the first set request strictly after
// last_i, wrapping modulo N. any_o is low when no request is set.
module rr_pick #(
    parameter int N = 11,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] grant_o,
    output logic         any_o
);

    logic [W:0]   cand;
    logic [W-1:0] grant;
    logic         found;

    // Walk N candidates starting at last_i+1; the first hit wins.
    always_comb begin
        cand  = '0;
        grant = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand = {1'b0, last_i} + (W+1)'(i);
            if (cand >= (W+1)'(N)) begin
                cand = cand - (W+1)'(N);
            end
            if (!found && req_i[cand[W-1:0]]) begin
                found = 1'b1;
                grant = cand[W-1:0];
            end
        end
        grant_o = grant;
        any_o   = found;
    end

endmodule

// File: rtl/enemy_fire_sched.sv
// Enemy fire scheduler: paces alien shots by frame count, picks the shooting
// column round-robin among live columns, and assigns the lowest free bullet
// slot. Commands leave over valid/ready: valid stays high with a stable
// column/slot until ready is seen, and is only withdrawn when enable_i drops.
module enemy_fire_sched
    import spaceinvaders_pkg::*;
#(
    parameter int NUM_COLS        = DEF_NUM_COLS,
    parameter int NUM_SLOTS       = DEF_NUM_SLOTS,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
    parameter int COL_W           = $clog2(NUM_COLS),
    parameter int SLOT_W          = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    parameter int CD_W            = $clog2(COOLDOWN_FRAMES + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 frame_i,
    input  logic                 enable_i,
    input  logic [NUM_COLS-1:0]  col_alive_i,
    input  logic [NUM_SLOTS-1:0] slot_done_i,
    output logic                 fire_valid_o,
    output logic [COL_W-1:0]     fire_col_o,
    output logic [SLOT_W-1:0]    fire_slot_o,
    input  logic                 ready_i,
    output logic [NUM_SLOTS-1:0] slot_busy_o
);

    fire_sched_states_t   state_q, state_d;
    logic [CD_W-1:0]      cd_q, cd_d;
    logic [COL_W-1:0]     last_col_q, last_col_d;
    logic [NUM_SLOTS-1:0] busy_q, busy_d;
    logic [COL_W-1:0]     fire_col_q, fire_col_d;
    logic [SLOT_W-1:0]    fire_slot_q, fire_slot_d;

    logic [COL_W-1:0]     pick_col;
    logic                 any_alive;
    logic [SLOT_W-1:0]    free_slot;
    logic                 any_free;
    logic                 handshake;

    assign handshake = (state_q == FS_OFFER) && ready_i;

    rr_pick #(.N(NUM_COLS), .W(COL_W)) u_col_pick (
        .req_i   (col_alive_i),
        .last_i  (last_col_q),
        .grant_o (pick_col),
        .any_o   (any_alive)
    );

    // Lowest-index free slot; scanning downward lets the lowest index win.
    always_comb begin
        free_slot = '0;
        any_free  = 1'b0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (!busy_q[s]) begin
                free_slot = SLOT_W'(s);
                any_free  = 1'b1;
            end
        end
    end

    // Slot ownership: done clears, an accepted command sets; set wins.
    always_comb begin
        busy_d = busy_q & ~slot_done_i;
        if (handshake) begin
            busy_d[fire_slot_q] = 1'b1;
        end
    end

    // Next-state logic: cooldown countdown, column/slot latch, handshake.
    always_comb begin
        state_d     = state_q;
        cd_d        = cd_q;
        last_col_d  = last_col_q;
        fire_col_d  = fire_col_q;
        fire_slot_d = fire_slot_q;
        // A command accepted in the same cycle enable_i drops still counts.
        if (handshake) begin
            last_col_d = fire_col_q;
        end
        if (!enable_i) begin
            state_d = FS_IDLE;
        end else begin
            case (state_q)
                FS_IDLE: begin
                    cd_d    = CD_W'(COOLDOWN_FRAMES);
                    state_d = FS_COOLDOWN;
                end
                FS_COOLDOWN: begin
                    // At zero, frames are ignored so the counter cannot wrap.
                    if (cd_q == '0) begin
                        if (any_alive && any_free) begin
                            state_d     = FS_OFFER;
                            fire_col_d  = pick_col;
                            fire_slot_d = free_slot;
                        end
                    end else if (frame_i) begin
                        cd_d = cd_q - CD_W'(1);
                    end
                end
                FS_OFFER: begin
                    if (ready_i) begin
                        cd_d    = CD_W'(COOLDOWN_FRAMES);
                        state_d = FS_COOLDOWN;
                    end
                end
                default: begin
                    state_d = FS_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= FS_IDLE;
            cd_q        <= CD_W'(COOLDOWN_FRAMES);
            last_col_q  <= COL_W'(NUM_COLS - 1);
            busy_q      <= '0;
            fire_col_q  <= '0;
            fire_slot_q <= '0;
        end else begin
            state_q     <= state_d;
            cd_q        <= cd_d;
            last_col_q  <= last_col_d;
            busy_q      <= busy_d;
            fire_col_q  <= fire_col_d;
            fire_slot_q <= fire_slot_d;
        end
    end

    assign fire_valid_o = (state_q == FS_OFFER);
    assign fire_col_o   = fire_col_q;
    assign fire_slot_o  = fire_slot_q;
    assign slot_busy_o  = busy_q;

    // The datapath must never retire the slot it is being handed.
    done_vs_grant_a: assert property (@(posedge clk_i) disable iff (!reset_i)
        !(handshake && slot_done_i[fire_slot_q]));

endmodule

// File: tb/tb_enemy_fire_sched.sv
// Bench for enemy_fire_sched with 11 columns, 3 slots and a 2-frame cooldown.
module tb_enemy_fire_sched;

    localparam int CD = 2;

    logic        clk;
    logic        reset_i;
    logic        frame_i;
    logic        enable_i;
    logic        ready_i;
    logic [10:0] col_alive;
    logic [2:0]  slot_done;
    logic        fire_valid;
    logic [3:0]  fire_col;
    logic [1:0]  fire_slot;
    logic [2:0]  slot_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] exp_q[$];
    logic [5:0] mon_e;

    typedef struct {
        logic [10:0] alive;
        logic [2:0]  done;
        logic [3:0]  col;
        logic [1:0]  slot;
        logic [2:0]  busy;
    } vec_t;

    vec_t vecs[8];

    enemy_fire_sched #(
        .NUM_COLS        (11),
        .NUM_SLOTS       (3),
        .COOLDOWN_FRAMES (CD)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .frame_i      (frame_i),
        .enable_i     (enable_i),
        .col_alive_i  (col_alive),
        .slot_done_i  (slot_done),
        .fire_valid_o (fire_valid),
        .fire_col_o   (fire_col),
        .fire_slot_o  (fire_slot),
        .ready_i      (ready_i),
        .slot_busy_o  (slot_busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted command must match the head of exp_q.
    always @(negedge clk) begin
        if (reset_i && fire_valid && ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_fire: got col %0d slot %0d, required no fire", fire_col, fire_slot);
            end else begin
                mon_e = exp_q.pop_front();
                check("fire_cmd", 32'({fire_col, fire_slot}), 32'(mon_e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_i = 1'b1;
        tick();
        frame_i = 1'b0;
    endtask

    task automatic pulse_done(input logic [2:0] d);
        slot_done = d;
        tick();
        slot_done = 3'b000;
    endtask

    task automatic wait_valid(input int bound, input string name);
        int n;
        n = 0;
        while (!fire_valid && n < bound) begin
            tick();
            n++;
        end
        check(name, 32'(fire_valid), 32'd1);
    endtask

    // Expect one command, let the cooldown elapse, and accept it (ready_i high).
    task automatic fire_one(input logic [3:0] col, input logic [1:0] slot);
        exp_q.push_back({col, slot});
        repeat (CD) pulse_frame();
        wait_valid(8, "offer_timeout");
        tick();
        check("valid_low_after_hs", 32'(fire_valid), 32'd0);
    endtask

    task automatic no_offer_window(input int cycles, input string name);
        logic saw;
        saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (i == 4) pulse_frame();
            else tick();
            saw = saw | fire_valid;
        end
        check(name, 32'(saw), 32'd0);
    endtask

    initial begin
        vecs[0] = '{11'h025, 3'b000, 4'd0,  2'd0, 3'b001};
        vecs[1] = '{11'h025, 3'b000, 4'd2,  2'd1, 3'b011};
        vecs[2] = '{11'h025, 3'b001, 4'd5,  2'd0, 3'b011};
        vecs[3] = '{11'h025, 3'b001, 4'd0,  2'd0, 3'b011};
        vecs[4] = '{11'h400, 3'b010, 4'd10, 2'd1, 3'b011};
        vecs[5] = '{11'h7FF, 3'b000, 4'd0,  2'd2, 3'b111};
        vecs[6] = '{11'h7FF, 3'b111, 4'd1,  2'd0, 3'b001};
        vecs[7] = '{11'h008, 3'b100, 4'd3,  2'd1, 3'b011};

        reset_i   = 1'b0;
        frame_i   = 1'b0;
        enable_i  = 1'b0;
        ready_i   = 1'b0;
        col_alive = '0;
        slot_done = '0;
        #1;
        check("rst_valid", 32'(fire_valid), 32'd0);
        check("rst_col",   32'(fire_col),   32'd0);
        check("rst_slot",  32'(fire_slot),  32'd0);
        check("rst_busy",  32'(slot_busy),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b1;

        // Basic fire: exact offer latency, first column 0, slot 0.
        enable_i  = 1'b1;
        col_alive = 11'h7FF;
        tick();
        repeat (CD) pulse_frame();
        check("no_early_offer", 32'(fire_valid), 32'd0);
        tick();
        check("basic_valid", 32'(fire_valid), 32'd1);
        check("basic_col",   32'(fire_col),   32'd0);
        check("basic_slot",  32'(fire_slot),  32'd0);
        exp_q.push_back({4'd0, 2'd0});
        ready_i = 1'b1;
        tick();
        check("basic_valid_after_hs", 32'(fire_valid), 32'd0);
        check("basic_busy",           32'(slot_busy),  32'd1);

        // Fresh start for the rotation table.
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            col_alive = vecs[i].alive;
            if (vecs[i].done != 3'b000) pulse_done(vecs[i].done);
            fire_one(vecs[i].col, vecs[i].slot);
            check("busy_after_hs", 32'(slot_busy), 32'(vecs[i].busy));
        end

        // Slot exhaustion, then a freed slot is used one cycle later.
        col_alive = 11'h7FF;
        fire_one(4'd4, 2'd2);
        check("busy_full", 32'(slot_busy), 32'h7);
        repeat (CD) pulse_frame();
        no_offer_window(15, "no_offer_when_full");
        pulse_done(3'b010);
        check("busy_after_done", 32'(slot_busy), 32'h5);
        exp_q.push_back({4'd5, 2'd1});
        tick();
        check("offer_after_free", 32'(fire_valid), 32'd1);
        check("freed_slot",       32'(fire_slot),  32'd1);
        tick();
        check("busy_refilled", 32'(slot_busy), 32'h7);

        // Backpressure with the offered column dying mid-offer.
        ready_i = 1'b0;
        pulse_done(3'b100);
        repeat (CD) pulse_frame();
        wait_valid(8, "bp_offer");
        for (int i = 0; i < 10; i++) begin
            if (i == 3) col_alive = 11'h000;
            tick();
            check("bp_valid", 32'(fire_valid), 32'd1);
            check("bp_col",   32'(fire_col),   32'd6);
            check("bp_slot",  32'(fire_slot),  32'd2);
        end
        exp_q.push_back({4'd6, 2'd2});
        ready_i = 1'b1;
        tick();
        check("bp_valid_after_hs", 32'(fire_valid), 32'd0);
        check("bp_busy",           32'(slot_busy),  32'h7);

        // No targets: hold in cooldown, then column 10 appears.
        pulse_done(3'b111);
        repeat (CD) pulse_frame();
        no_offer_window(10, "no_offer_no_targets");
        col_alive = 11'h400;
        exp_q.push_back({4'd10, 2'd0});
        tick();
        check("target_valid", 32'(fire_valid), 32'd1);
        check("target_col",   32'(fire_col),   32'd10);
        tick();
        check("target_busy", 32'(slot_busy), 32'h1);

        // Abort: enable drops during an offer.
        ready_i   = 1'b0;
        col_alive = 11'h7FF;
        repeat (CD) pulse_frame();
        wait_valid(8, "abort_offer");
        check("abort_col",  32'(fire_col),  32'd0);
        check("abort_slot", 32'(fire_slot), 32'd1);
        enable_i = 1'b0;
        tick();
        check("abort_valid", 32'(fire_valid), 32'd0);
        check("abort_busy",  32'(slot_busy),  32'h1);

        // Asynchronous reset in the middle of an offer.
        enable_i = 1'b1;
        tick();
        repeat (CD) pulse_frame();
        wait_valid(8, "reset_offer");
        #2;
        reset_i = 1'b0;
        #1;
        check("async_rst_valid", 32'(fire_valid), 32'd0);
        check("async_rst_col",   32'(fire_col),   32'd0);
        check("async_rst_slot",  32'(fire_slot),  32'd0);
        check("async_rst_busy",  32'(slot_busy),  32'd0);
        tick();
        reset_i = 1'b1;
        tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
